conv_stream_engine: RTL and testbench

Parametrised streaming 2-D convolution engine: the next-generation conv layer datapath. Accepts one raster-ordered pixel per cycle over a valid/ready stream and buffers K−1 rows internally. Forms a K×K window and emits one valid-mode feature pixel per cycle through a 3-stage MAC pipeline with full backpressure. Sits between the input pixel source and the activation/output stage; coefficients are written through a register port while idle.

---
 rtl/conv_pkg.sv | 34 +++
 rtl/conv_line_buffer.sv | 69 ++++++
 rtl/conv_stream_engine.sv | 191 +++++++++++++++++++
 tb/tb_conv_stream_engine.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and helpers for the streaming convolution engine: FSM state
// encoding, default geometry and the shift/saturate helper used by the output stage.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    localparam int CFG_IMAGE_SIZE  = 8;
    localparam int CFG_KERNEL_SIZE = 3;
    localparam int OUT_SIZE        = CFG_IMAGE_SIZE - CFG_KERNEL_SIZE + 1;

    // Arithmetic shift (floor) followed by clamping to a signed dw-bit range.
    function automatic logic signed [63:0] conv_sat(input logic signed [63:0] v,
                                                    input int frac,
                                                    input int dw);
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = v >>> frac;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (s > hi) begin
            return hi;
        end
        if (s < lo) begin
            return lo;
        end
        return s;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// K-1 row delay lines feeding a KxK sliding window; window_flat presents the
// window as it will be after the current shift, so it already includes pixel_in.
module conv_line_buffer
    import conv_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int IMAGE_SIZE  = 8,
    parameter int KERNEL_SIZE = 3
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       shift_en,
    input  logic [DATA_W-1:0]                          pixel_in,
    output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_W-1:0]  window_flat
);

    logic [DATA_W-1:0] row_q [KERNEL_SIZE-1][IMAGE_SIZE];
    logic [DATA_W-1:0] row_d [KERNEL_SIZE-1][IMAGE_SIZE];
    logic [DATA_W-1:0] win_q [KERNEL_SIZE][KERNEL_SIZE];
    logic [DATA_W-1:0] win_d [KERNEL_SIZE][KERNEL_SIZE];
    logic [DATA_W-1:0] tap   [KERNEL_SIZE];

    // tap[r] is the pixel in the current column from (K-1-r) rows earlier.
    always_comb begin
        tap[KERNEL_SIZE-1] = pixel_in;
        for (int j = 0; j < KERNEL_SIZE - 1; j++) begin
            tap[j] = row_q[j][IMAGE_SIZE-1];
        end
        row_d = row_q;
        win_d = win_q;
        for (int r = 0; r < KERNEL_SIZE; r++) begin
            for (int c = 0; c < KERNEL_SIZE - 1; c++) begin
                win_d[r][c] = win_q[r][c+1];
            end
            win_d[r][KERNEL_SIZE-1] = tap[r];
        end
        for (int j = 0; j < KERNEL_SIZE - 1; j++) begin
            row_d[j][0] = tap[j+1];
            for (int i = 1; i < IMAGE_SIZE; i++) begin
                row_d[j][i] = row_q[j][i-1];
            end
        end
        window_flat = '0;
        for (int r = 0; r < KERNEL_SIZE; r++) begin
            for (int c = 0; c < KERNEL_SIZE; c++) begin
                window_flat[(r*KERNEL_SIZE+c)*DATA_W +: DATA_W] = win_d[r][c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < KERNEL_SIZE - 1; j++) begin
                for (int i = 0; i < IMAGE_SIZE; i++) begin
                    row_q[j][i] <= '0;
                end
            end
            for (int r = 0; r < KERNEL_SIZE; r++) begin
                for (int c = 0; c < KERNEL_SIZE; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else if (shift_en) begin
            row_q <= row_d;
            win_q <= win_d;
        end
    end

endmodule

// File: rtl/conv_stream_engine.sv
// Streaming valid-mode KxK convolution with a 3-stage MAC pipeline and full
// backpressure. Optional macro CONV_RELU_EN clamps negative results to zero.
module conv_stream_engine
    import conv_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int COEF_W      = 16,
    parameter int ACC_W       = 40,
    parameter int FRAC_W      = 8,
    parameter int IMAGE_SIZE  = CFG_IMAGE_SIZE,
    parameter int KERNEL_SIZE = CFG_KERNEL_SIZE
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          start,
    output logic                                          busy,
    output logic                                          frame_done,
    input  logic                                          w_we,
    input  logic [$clog2(KERNEL_SIZE*KERNEL_SIZE)-1:0]    w_addr,
    input  logic [COEF_W-1:0]                             w_data,
    input  logic                                          s_valid,
    output logic                                          s_ready,
    input  logic [DATA_W-1:0]                             s_pixel,
    output logic                                          m_valid,
    input  logic                                          m_ready,
    output logic [DATA_W-1:0]                             m_pixel,
    output logic                                          m_last,
    output logic [1:0]                                    dbg_state
);

    localparam int KK    = KERNEL_SIZE * KERNEL_SIZE;
    localparam int AW    = $clog2(KK);
    localparam int CNT_W = $clog2(IMAGE_SIZE + 1);
    localparam int PW    = DATA_W + COEF_W;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          row_q, row_d, col_q, col_d;
    logic signed [COEF_W-1:0]  coef_q [KK];
    logic signed [COEF_W-1:0]  coef_d [KK];
    logic signed [PW-1:0]      prod_q [KK];
    logic signed [PW-1:0]      prod_d [KK];
    logic                      v1_q, v1_d, l1_q, l1_d, v2_q, v2_d, l2_q, l2_d;
    logic signed [ACC_W-1:0]   sum_q, sum_d;
    logic                      m_valid_q, m_valid_d, m_last_q, m_last_d;
    logic [DATA_W-1:0]         m_pixel_q, m_pixel_d;
    logic                      stall, accept, win_valid, win_last, last_px;
    logic [KK*DATA_W-1:0]      window_flat;
    logic signed [DATA_W-1:0]  win_px [KK];
    logic signed [63:0]        res;

    // Both streams transfer on a cycle where valid and ready are high together;
    // a stalled output (m_valid & ~m_ready) freezes the pipeline, window and counters.
    assign stall     = m_valid_q & ~m_ready;
    assign s_ready   = (state_q == STREAM) & ~stall;
    assign accept    = s_valid & s_ready;
    assign last_px   = (row_q == CNT_W'(IMAGE_SIZE - 1)) && (col_q == CNT_W'(IMAGE_SIZE - 1));
    assign win_valid = accept && (row_q >= CNT_W'(KERNEL_SIZE - 1)) && (col_q >= CNT_W'(KERNEL_SIZE - 1));
    assign win_last  = accept && last_px;

    assign busy      = (state_q != IDLE);
    assign m_valid   = m_valid_q;
    assign m_pixel   = m_pixel_q;
    assign m_last    = m_last_q;
    assign dbg_state = state_q;

    conv_line_buffer #(
        .DATA_W      (DATA_W),
        .IMAGE_SIZE  (IMAGE_SIZE),
        .KERNEL_SIZE (KERNEL_SIZE)
    ) u_line_buffer (
        .clk         (clk),
        .rst         (rst),
        .shift_en    (accept),
        .pixel_in    (s_pixel),
        .window_flat (window_flat)
    );

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        coef_d     = coef_q;
        frame_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = STREAM;
                    row_d   = '0;
                    col_d   = '0;
                end
                if (w_we && ({1'b0, w_addr} < (AW+1)'(KK))) begin
                    coef_d[w_addr] = w_data;
                end
            end
            STREAM: begin
                if (accept) begin
                    if (col_q == CNT_W'(IMAGE_SIZE - 1)) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                    if (last_px) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!v1_q && !v2_q && !m_valid_q) begin
                    frame_done = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        v1_d      = v1_q;
        l1_d      = l1_q;
        prod_d    = prod_q;
        v2_d      = v2_q;
        l2_d      = l2_q;
        sum_d     = sum_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        m_pixel_d = m_pixel_q;
        for (int i = 0; i < KK; i++) begin
            win_px[i] = window_flat[i*DATA_W +: DATA_W];
        end
        res = conv_sat(64'(sum_q), FRAC_W, DATA_W);
`ifdef CONV_RELU_EN
        if (res < 0) begin
            res = '0;
        end
`endif
        if (!stall) begin
            v1_d = win_valid;
            l1_d = win_last;
            for (int i = 0; i < KK; i++) begin
                prod_d[i] = PW'(win_px[i]) * PW'(coef_q[i]);
            end
            v2_d  = v1_q;
            l2_d  = l1_q;
            sum_d = '0;
            for (int i = 0; i < KK; i++) begin
                sum_d = sum_d + ACC_W'(prod_q[i]);
            end
            m_valid_d = v2_q;
            m_last_d  = l2_q;
            if (v2_q) begin
                m_pixel_d = res[DATA_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            row_q     <= '0;
            col_q     <= '0;
            for (int i = 0; i < KK; i++) begin
                coef_q[i] <= '0;
                prod_q[i] <= '0;
            end
            v1_q      <= 1'b0;
            l1_q      <= 1'b0;
            v2_q      <= 1'b0;
            l2_q      <= 1'b0;
            sum_q     <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_pixel_q <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            coef_q    <= coef_d;
            prod_q    <= prod_d;
            v1_q      <= v1_d;
            l1_q      <= l1_d;
            v2_q      <= v2_d;
            l2_q      <= l2_d;
            sum_q     <= sum_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            m_pixel_q <= m_pixel_d;
        end
    end

endmodule

// File: tb/tb_conv_stream_engine.sv
// Randomized bench for conv_stream_engine: a direct-convolution model fills an
// expected queue that is checked against every output handshake.
module tb_conv_stream_engine;
    import conv_pkg::*;

    localparam int DATA_W    = 16;
    localparam int COEF_W    = 16;
    localparam int IMG       = CFG_IMAGE_SIZE;
    localparam int K         = CFG_KERNEL_SIZE;
    localparam int NPIX      = IMG * IMG;
    localparam int FIRST_IDX = (K - 1) * IMG + K - 1;
    localparam int MAX_CYC   = 3000;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       start = 1'b0;
    logic                       busy, frame_done;
    logic                       w_we = 1'b0;
    logic [$clog2(K*K)-1:0]     w_addr = '0;
    logic [COEF_W-1:0]          w_data = '0;
    logic                       s_valid = 1'b0;
    logic                       s_ready;
    logic [DATA_W-1:0]          s_pixel = '0;
    logic                       m_valid;
    logic                       m_ready = 1'b1;
    logic [DATA_W-1:0]          m_pixel;
    logic                       m_last;
    logic [1:0]                 dbg_state;

    int img  [NPIX];
    int coef [K*K];
    logic [DATA_W-1:0] exp_q[$];
    bit                exp_last_q[$];
    int n_cmp = 0;
    int n_err = 0;

    conv_stream_engine #(
        .DATA_W(DATA_W), .COEF_W(COEF_W), .ACC_W(40), .FRAC_W(0),
        .IMAGE_SIZE(IMG), .KERNEL_SIZE(K)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .frame_done(frame_done),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .s_valid(s_valid), .s_ready(s_ready), .s_pixel(s_pixel),
        .m_valid(m_valid), .m_ready(m_ready), .m_pixel(m_pixel), .m_last(m_last),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Reference: direct valid-mode convolution, floor shift, clamp, optional ReLU.
    task automatic build_expected();
        longint s;
        longint hi;
        longint lo;
        exp_q.delete();
        exp_last_q.delete();
        hi = (64'sd1 <<< (DATA_W - 1)) - 1;
        lo = -hi - 1;
        for (int r = 0; r < OUT_SIZE; r++) begin
            for (int c = 0; c < OUT_SIZE; c++) begin
                s = 0;
                for (int kr = 0; kr < K; kr++) begin
                    for (int kc = 0; kc < K; kc++) begin
                        s += longint'(img[(r+kr)*IMG + c + kc]) * longint'(coef[kr*K + kc]);
                    end
                end
                if (s > hi) s = hi;
                if (s < lo) s = lo;
`ifdef CONV_RELU_EN
                if (s < 0) s = 0;
`endif
                exp_q.push_back(DATA_W'(s));
                exp_last_q.push_back((r == OUT_SIZE - 1) && (c == OUT_SIZE - 1));
            end
        end
    endtask

    task automatic load_coefs();
        for (int i = 0; i < K * K; i++) begin
            w_we = 1'b1; w_addr = ($clog2(K*K))'(i); w_data = COEF_W'(coef[i]);
            @(negedge clk);
        end
        // out-of-range address must not disturb any coefficient
        w_we = 1'b1; w_addr = '1; w_data = 16'h1234;
        @(negedge clk);
        w_we = 1'b0;
    endtask

    task automatic set_identity();
        for (int i = 0; i < K * K; i++) coef[i] = (i == (K * K) / 2) ? 1 : 0;
    endtask

    task automatic set_ramp();
        for (int i = 0; i < NPIX; i++) img[i] = i;
    endtask

    // ready_mode: 0 always ready, 1 random, 2 hold low 5 cycles at first output
    task automatic run_frame(input int ready_mode, input bit gaps, input bit inject,
                             input int abort_at);
        int idx = 0, got = 0, cyc = 0, acc_cyc = -1, first_cyc = -1;
        int last_cyc = -1, done_cyc = -1, done_cnt = 0, hold = 0, n_exp;
        bit prev_stall = 0;
        logic [DATA_W-1:0] prev_pix = '0;
        build_expected();
        n_exp = exp_q.size();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++; $display("FAIL start_busy: busy=%b expected 1", busy);
        end
        while (cyc < MAX_CYC) begin
            s_valid = (idx < NPIX) && (abort_at < 0 || idx < abort_at) &&
                      (!gaps || $urandom_range(0, 3) != 0);
            s_pixel = (idx < NPIX) ? DATA_W'(img[idx]) : DATA_W'($urandom);
            if (ready_mode == 1) m_ready = ($urandom_range(0, 2) != 0);
            else if (ready_mode == 2 && m_valid && got == 0 && hold < 5) begin
                m_ready = 1'b0; hold++;
            end else m_ready = 1'b1;
            w_we   = inject && (idx == 10);
            w_addr = 4; w_data = 7;
            start  = inject && (idx == NPIX);
            #1;
            if (s_valid && s_ready) begin
                if (idx == FIRST_IDX) acc_cyc = cyc;
                idx++;
            end
            if (m_valid && first_cyc < 0) first_cyc = cyc;
            if (ready_mode == 2 && !m_ready && m_valid) begin
                n_cmp += 2;
                if (m_pixel !== exp_q[0]) begin
                    n_err++; $display("FAIL hold_pixel: m_pixel=%0d expected %0d", $signed(m_pixel), $signed(exp_q[0]));
                end
                if (s_ready !== 1'b0) begin
                    n_err++; $display("FAIL hold_s_ready: s_ready=%b expected 0", s_ready);
                end
            end
            if (prev_stall) begin
                n_cmp++;
                if (m_pixel !== prev_pix) begin
                    n_err++; $display("FAIL stall_stable: m_pixel=%0d expected %0d", $signed(m_pixel), $signed(prev_pix));
                end
            end
            if (m_valid && m_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL extra_output: m_pixel=%0d expected none", $signed(m_pixel));
                end else begin
                    if (m_pixel !== exp_q[0] || m_last !== exp_last_q[0]) begin
                        n_err++;
                        $display("FAIL output[%0d]: pixel=%0d last=%b expected pixel=%0d last=%b",
                                 got, $signed(m_pixel), m_last, $signed(exp_q[0]), exp_last_q[0]);
                    end
                    void'(exp_q.pop_front());
                    void'(exp_last_q.pop_front());
                end
                got++;
                if (got == n_exp) last_cyc = cyc;
            end
            if (frame_done) begin done_cnt++; done_cyc = cyc; end
            prev_stall = m_valid && !m_ready;
            prev_pix   = m_pixel;
            cyc++;
            @(negedge clk);
            if (done_cnt > 0 || (abort_at >= 0 && idx >= abort_at)) break;
        end
        s_valid = 1'b0; start = 1'b0; w_we = 1'b0; m_ready = 1'b1;
        if (abort_at >= 0) begin
            exp_q.delete(); exp_last_q.delete();
            return;
        end
        n_cmp += 3;
        if (cyc >= MAX_CYC) begin
            n_err++; $display("FAIL timeout: cycles=%0d limit %0d", cyc, MAX_CYC);
        end
        if (got !== n_exp || done_cnt !== 1) begin
            n_err++; $display("FAIL frame_count: outputs=%0d done_pulses=%0d expected %0d and 1", got, done_cnt, n_exp);
        end
        if (done_cyc !== last_cyc + 1) begin
            n_err++; $display("FAIL done_timing: done_cycle=%0d expected %0d", done_cyc, last_cyc + 1);
        end
        if (ready_mode == 0 && !gaps) begin
            n_cmp++;
            if (first_cyc - acc_cyc !== 3) begin
                n_err++; $display("FAIL latency: got %0d cycles expected 3", first_cyc - acc_cyc);
            end
        end
    endtask

    task automatic test_reset();
        n_cmp += 6;
        if (s_ready !== 1'b0)  begin n_err++; $display("FAIL reset_s_ready: %b expected 0", s_ready); end
        if (m_valid !== 1'b0)  begin n_err++; $display("FAIL reset_m_valid: %b expected 0", m_valid); end
        if (m_pixel !== '0)    begin n_err++; $display("FAIL reset_m_pixel: %0d expected 0", m_pixel); end
        if (m_last !== 1'b0)   begin n_err++; $display("FAIL reset_m_last: %b expected 0", m_last); end
        if (busy !== 1'b0)     begin n_err++; $display("FAIL reset_busy: %b expected 0", busy); end
        if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_frame_done: %b expected 0", frame_done); end
    endtask

    task automatic test_identity();
        set_identity(); set_ramp(); load_coefs();
        run_frame(0, 0, 0, -1);
    endtask

    task automatic test_all_ones();
        for (int i = 0; i < K * K; i++) coef[i] = 1;
        set_ramp(); load_coefs();
        run_frame(1, 1, 0, -1);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < K * K; i++) coef[i] = 1;
        load_coefs();
        for (int i = 0; i < NPIX; i++) img[i] = 32767;
        run_frame(1, 0, 0, -1);
        for (int i = 0; i < NPIX; i++) img[i] = -32768;
        run_frame(0, 1, 0, -1);
    endtask

    task automatic test_backpressure();
        set_identity(); set_ramp(); load_coefs();
        run_frame(2, 0, 0, -1);
    endtask

    task automatic test_random();
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < K * K; i++) coef[i] = int'($urandom_range(0, 100)) - 50;
            for (int i = 0; i < NPIX; i++) img[i] = (t == 2) ? int'($urandom_range(0, 65535)) - 32768
                                                              : int'($urandom_range(0, 400)) - 200;
            load_coefs();
            run_frame(1, 1, 0, -1);
        end
    endtask

    task automatic test_busy_ignores();
        set_identity(); set_ramp(); load_coefs();
        run_frame(0, 0, 1, -1);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL drain_start_ignored: busy=%b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < K * K; i++) coef[i] = int'($urandom_range(0, 20)) - 10;
        for (int i = 0; i < NPIX; i++) img[i] = int'($urandom_range(0, 1000)) - 500;
        load_coefs();
        run_frame(1, 1, 0, -1);
        run_frame(0, 0, 0, -1);
    endtask

    task automatic test_abort();
        set_identity(); set_ramp(); load_coefs();
        run_frame(0, 0, 0, 20);
        rst = 1'b1;
        @(negedge clk);
        n_cmp += 3;
        if (busy !== 1'b0)    begin n_err++; $display("FAIL abort_busy: %b expected 0", busy); end
        if (m_valid !== 1'b0) begin n_err++; $display("FAIL abort_m_valid: %b expected 0", m_valid); end
        if (s_ready !== 1'b0) begin n_err++; $display("FAIL abort_s_ready: %b expected 0", s_ready); end
        rst = 1'b0;
        @(negedge clk);
        // coefficients were cleared by reset, so an unloaded frame yields zeros
        for (int i = 0; i < K * K; i++) coef[i] = 0;
        run_frame(0, 0, 0, -1);
        set_identity(); load_coefs();
        run_frame(1, 1, 0, -1);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_identity();
        test_all_ones();
        test_saturation();
        test_backpressure();
        test_random();
        test_busy_ignores();
        test_back_to_back();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
